// File: rtl/fsm_stream_sequencer.sv
// Run controller for a 4-state Mealy detector FSM.
// It resets the FSM, drives a latched bit pattern onto X LSB-first, logs every Y, and counts Y == TARGET hits.
module fsm_stream_sequencer #(
  parameter int          N_BITS = 8,
  parameter int          CNT_W  = 4,
  parameter logic [1:0]  TARGET = 2'b10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_BITS-1:0]     pattern,
  input  logic [CNT_W-1:0]      length,
  input  logic [1:0]            fsm_y,
  output logic                  fsm_x,
  output logic                  fsm_reset,
  output logic                  busy,
  output logic                  done,
  output logic [2*N_BITS-1:0]   y_log,
  output logic [CNT_W-1:0]      hit_count
);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_e;

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(N_BITS);

  state_e                state_q, state_d;
  logic [N_BITS-1:0]     shreg_q, shreg_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      hit_q, hit_d;
  logic [2*N_BITS-1:0]   ylog_q, ylog_d;
  logic                  fsm_rst_st;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    len_d      = len_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    ylog_d     = ylog_q;
    fsm_x      = 1'b0;
    fsm_rst_st = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = pattern;
          len_d   = (length > MAX_LEN) ? MAX_LEN : length;
          idx_d   = '0;
          hit_d   = '0;
          ylog_d  = '0;
          state_d = S_RST;
        end
      end
      S_RST: begin
        busy       = 1'b1;
        fsm_rst_st = 1'b1;
        state_d    = (len_q != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        busy  = 1'b1;
        fsm_x = shreg_q[0];
        // Y is Mealy, so it reflects the X driven in this same cycle
        for (int i = 0; i < N_BITS; i++) begin
          if (idx_q == CNT_W'(i)) ylog_d[2*i +: 2] = fsm_y;
        end
        if (fsm_y == TARGET) hit_d = hit_q + CNT_W'(1);
        shreg_d = shreg_q >> 1;
        idx_d   = idx_q + CNT_W'(1);
        if (idx_q == len_q - CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hit_q   <= '0;
      ylog_q  <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      ylog_q  <= ylog_d;
    end
  end

  // Pattern, length and index are reloaded on every accepted start
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    len_q   <= len_d;
    idx_q   <= idx_d;
  end

  assign fsm_reset = reset | fsm_rst_st;
  assign y_log     = ylog_q;
  assign hit_count = hit_q;

endmodule
